// File: rtl/ps2_keypad_pkg.sv
// rtl/ps2_keypad_pkg.sv - PS/2 scan-code constants, receiver state encodings and the Chip-8 key map
package ps2_keypad_pkg;

   // Prefix bytes of scan-code set 2
   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   // Set 2 make codes of the 16 keys that form the hex keypad
   localparam logic [7:0] PS2_KEY_1 = 8'h16;
   localparam logic [7:0] PS2_KEY_2 = 8'h1E;
   localparam logic [7:0] PS2_KEY_3 = 8'h26;
   localparam logic [7:0] PS2_KEY_4 = 8'h25;
   localparam logic [7:0] PS2_KEY_Q = 8'h15;
   localparam logic [7:0] PS2_KEY_W = 8'h1D;
   localparam logic [7:0] PS2_KEY_E = 8'h24;
   localparam logic [7:0] PS2_KEY_R = 8'h2D;
   localparam logic [7:0] PS2_KEY_A = 8'h1C;
   localparam logic [7:0] PS2_KEY_S = 8'h1B;
   localparam logic [7:0] PS2_KEY_D = 8'h23;
   localparam logic [7:0] PS2_KEY_F = 8'h2B;
   localparam logic [7:0] PS2_KEY_Z = 8'h1A;
   localparam logic [7:0] PS2_KEY_X = 8'h22;
   localparam logic [7:0] PS2_KEY_C = 8'h21;
   localparam logic [7:0] PS2_KEY_V = 8'h2A;

   // Receiver FSM encodings
   localparam logic [1:0] RX_IDLE   = 2'd0;
   localparam logic [1:0] RX_DATA   = 2'd1;
   localparam logic [1:0] RX_PARITY = 2'd2;
   localparam logic [1:0] RX_STOP   = 2'd3;

   typedef struct packed {
      logic       hit;
      logic [3:0] key;
   } key_map_t;

   // Translate a set 2 make code to its Chip-8 key; hit=0 for codes off the keypad
   function automatic key_map_t map_scan(input logic [7:0] code);
      key_map_t m;
      m.hit = 1'b1;
      m.key = 4'h0;
      case (code)
         PS2_KEY_1: m.key = 4'h1;
         PS2_KEY_2: m.key = 4'h2;
         PS2_KEY_3: m.key = 4'h3;
         PS2_KEY_4: m.key = 4'hC;
         PS2_KEY_Q: m.key = 4'h4;
         PS2_KEY_W: m.key = 4'h5;
         PS2_KEY_E: m.key = 4'h6;
         PS2_KEY_R: m.key = 4'hD;
         PS2_KEY_A: m.key = 4'h7;
         PS2_KEY_S: m.key = 4'h8;
         PS2_KEY_D: m.key = 4'h9;
         PS2_KEY_F: m.key = 4'hE;
         PS2_KEY_Z: m.key = 4'hA;
         PS2_KEY_X: m.key = 4'h0;
         PS2_KEY_C: m.key = 4'hB;
         PS2_KEY_V: m.key = 4'hF;
         default:   m.hit = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_keypad_rx.sv
// rtl/ps2_keypad_rx.sv - PS/2 frame receiver: synchronisers, falling-edge detect, frame FSM, idle timeout
module ps2_keypad_rx
   import ps2_keypad_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1, clk_s2, clk_prev;
   logic          data_s1, data_s2;
   logic          fall;
   logic          stop_ok;
   logic          expire;
   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par;
   logic [TW-1:0] timer;

   // Two-flop synchronisers; reset to the idle-high line level so release never fakes an edge
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= ps2_data;
         data_s2  <= data_s1;
      end
   end

   // Edge detect, frame check and timeout expiry; results are flagged in the edge cycle itself
   always_comb begin
      fall     = clk_prev & ~clk_s2;
      stop_ok  = data_s2 & (^{shift, par});
      rx_valid = fall && (state == RX_STOP) && stop_ok;
      rx_err   = fall && (((state == RX_IDLE) && data_s2) ||
                          ((state == RX_STOP) && !stop_ok));
      rx_byte  = shift;
      expire   = (state != RX_IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
   end

   // Frame FSM: one step per ps2_clk falling edge, abandoned after a silent TIMEOUT_CYCLES
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state   <= RX_IDLE;
         bit_cnt <= 3'd0;
         shift   <= 8'h00;
         par     <= 1'b0;
         timer   <= '0;
      end else if (fall) begin
         timer <= '0;
         case (state)
            RX_IDLE: begin
               if (!data_s2) begin
                  state   <= RX_DATA;
                  bit_cnt <= 3'd0;
               end
            end
            RX_DATA: begin
               shift   <= {data_s2, shift[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= RX_PARITY;
            end
            RX_PARITY: begin
               par   <= data_s2;
               state <= RX_STOP;
            end
            default: state <= RX_IDLE;
         endcase
      end else if (expire) begin
         state <= RX_IDLE;
         timer <= '0;
      end else if (state != RX_IDLE) begin
         timer <= timer + 1'b1;
      end else begin
         timer <= '0;
      end
   end

endmodule

// File: rtl/ps2_keypad.sv
// rtl/ps2_keypad.sv - PS/2 set 2 decoder to Chip-8 hex keypad state; PS2_KEYPAD_RAW_EN adds raw byte ports
module ps2_keypad
   import ps2_keypad_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        res_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] keys,
   output logic        any_key,
   output logic        key_event,
   output logic [3:0]  key_code,
   output logic        key_pressed,
`ifdef PS2_KEYPAD_RAW_EN
   output logic        scan_valid,
   output logic [7:0]  scan_code,
`endif
   output logic        rx_error
);

   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_err;
   logic       brk;
   logic       ext;
   key_map_t   km;

   ps2_keypad_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk      (clk),
      .res_n    (res_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_err   (rx_err)
   );

   // Key lookup of the byte currently being accepted
   always_comb begin
      km      = map_scan(rx_byte);
      any_key = |keys;
   end

   // Prefix flags and key register; extended keys are consumed but never mapped
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         brk         <= 1'b0;
         ext         <= 1'b0;
         keys        <= 16'h0000;
         key_event   <= 1'b0;
         key_code    <= 4'h0;
         key_pressed <= 1'b0;
         rx_error    <= 1'b0;
      end else begin
         key_event <= 1'b0;
         rx_error  <= rx_err;
         if (rx_valid) begin
            if (rx_byte == PS2_BREAK) begin
               brk <= 1'b1;
            end else if (rx_byte == PS2_EXT) begin
               ext <= 1'b1;
            end else begin
               brk <= 1'b0;
               ext <= 1'b0;
               if (!ext && km.hit) begin
                  key_event      <= 1'b1;
                  key_code       <= km.key;
                  key_pressed    <= ~brk;
                  keys[km.key]   <= ~brk;
               end
            end
         end else if (rx_err) begin
            brk <= 1'b0;
            ext <= 1'b0;
         end
      end
   end

`ifdef PS2_KEYPAD_RAW_EN
   // Raw byte tap: every accepted byte, prefixes and unmapped codes included
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         scan_valid <= 1'b0;
         scan_code  <= 8'h00;
      end else begin
         scan_valid <= rx_valid;
         if (rx_valid) scan_code <= rx_byte;
      end
   end
`endif

endmodule

// File: tb/tb_ps2_keypad.sv
// tb/tb_ps2_keypad.sv - directed table-driven bench for ps2_keypad
module tb_ps2_keypad;

   localparam int TO = 200;

   logic        clk = 1'b0;
   logic        res_n;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] keys;
   logic        any_key;
   logic        key_event;
   logic [3:0]  key_code;
   logic        key_pressed;
   logic        rx_error;
`ifdef PS2_KEYPAD_RAW_EN
   logic        scan_valid;
   logic [7:0]  scan_code;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int ev_cnt   = 0;
   int err_cnt  = 0;

   ps2_keypad #(.TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .res_n       (res_n),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .keys        (keys),
      .any_key     (any_key),
      .key_event   (key_event),
      .key_code    (key_code),
      .key_pressed (key_pressed),
`ifdef PS2_KEYPAD_RAW_EN
      .scan_valid  (scan_valid),
      .scan_code   (scan_code),
`endif
      .rx_error    (rx_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_event) ev_cnt++;
      if (rx_error)  err_cnt++;
   end

   typedef struct {
      logic [7:0]  code;
      logic        bad;
      logic [15:0] keys;
      int          ev;
      logic [3:0]  kc;
      logic        kp;
      int          err;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad);
      logic p;
      p = ~(^code) ^ bad;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(code[i]);
      ps2_bit(p);
      ps2_bit(1'b1);
      repeat (10) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int e0, r0;

      vecs[0]  = '{8'h16, 1'b0, 16'h0002, 1, 4'h1, 1'b1, 0};
      vecs[1]  = '{8'hF0, 1'b0, 16'h0002, 0, 4'h0, 1'b0, 0};
      vecs[2]  = '{8'h16, 1'b0, 16'h0000, 1, 4'h1, 1'b0, 0};
      vecs[3]  = '{8'hE0, 1'b0, 16'h0000, 0, 4'h0, 1'b0, 0};
      vecs[4]  = '{8'h1C, 1'b0, 16'h0000, 0, 4'h0, 1'b0, 0};
      vecs[5]  = '{8'h1C, 1'b0, 16'h0080, 1, 4'h7, 1'b1, 0};
      vecs[6]  = '{8'h22, 1'b1, 16'h0080, 0, 4'h0, 1'b0, 1};
      vecs[7]  = '{8'h22, 1'b0, 16'h0081, 1, 4'h0, 1'b1, 0};
      vecs[8]  = '{8'h22, 1'b0, 16'h0081, 1, 4'h0, 1'b1, 0};
      vecs[9]  = '{8'h05, 1'b0, 16'h0081, 0, 4'h0, 1'b0, 0};
      vecs[10] = '{8'hF0, 1'b0, 16'h0081, 0, 4'h0, 1'b0, 0};
      vecs[11] = '{8'h1C, 1'b0, 16'h0001, 1, 4'h7, 1'b0, 0};
      vecs[12] = '{8'hF0, 1'b1, 16'h0001, 0, 4'h0, 1'b0, 1};
      vecs[13] = '{8'h22, 1'b0, 16'h0001, 1, 4'h0, 1'b1, 0};

      res_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("reset_keys", 32'(keys), 32'h0);
      check("reset_any_key", 32'(any_key), 32'h0);
      check("reset_key_event", 32'(key_event), 32'h0);
      check("reset_key_code", 32'(key_code), 32'h0);
      check("reset_key_pressed", 32'(key_pressed), 32'h0);
      check("reset_rx_error", 32'(rx_error), 32'h0);
      res_n = 1'b1;
      repeat (5) @(posedge clk);

      for (int i = 0; i < 14; i++) begin
         e0 = ev_cnt;
         r0 = err_cnt;
         send_frame(vecs[i].code, vecs[i].bad);
         check($sformatf("v%0d_keys", i), 32'(keys), 32'(vecs[i].keys));
         check($sformatf("v%0d_any_key", i), 32'(any_key), 32'(vecs[i].keys != 16'h0));
         check($sformatf("v%0d_events", i), 32'(ev_cnt - e0), 32'(vecs[i].ev));
         check($sformatf("v%0d_rx_error", i), 32'(err_cnt - r0), 32'(vecs[i].err));
         if (vecs[i].ev > 0) begin
            check($sformatf("v%0d_key_code", i), 32'(key_code), 32'(vecs[i].kc));
            check($sformatf("v%0d_key_pressed", i), 32'(key_pressed), 32'(vecs[i].kp));
         end
      end

      // Start bit of 1 while idle is a framing error
      e0 = ev_cnt;
      r0 = err_cnt;
      ps2_bit(1'b1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("start_bit_err", 32'(err_cnt - r0), 32'd1);
      check("start_bit_keys", 32'(keys), 32'h0001);

      // Partial frame, silence past the timeout, then a clean frame
      r0 = err_cnt;
      e0 = ev_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      repeat (TO + 100) @(posedge clk);
      send_frame(8'h2A, 1'b0);
      check("timeout_keys", 32'(keys), 32'h8001);
      check("timeout_events", 32'(ev_cnt - e0), 32'd1);
      check("timeout_key_code", 32'(key_code), 32'hF);
      check("timeout_no_err", 32'(err_cnt - r0), 32'd0);

      // Reset mid-frame clears keys immediately; the next frame decodes cleanly
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      @(negedge clk);
      res_n = 1'b0;
      #1;
      check("midreset_keys", 32'(keys), 32'h0);
      check("midreset_any_key", 32'(any_key), 32'h0);
      repeat (5) @(posedge clk);
      res_n = 1'b1;
      repeat (5) @(posedge clk);
      r0 = err_cnt;
      e0 = ev_cnt;
      send_frame(8'h25, 1'b0);
      check("post_reset_keys", 32'(keys), 32'h1000);
      check("post_reset_key_code", 32'(key_code), 32'hC);
      check("post_reset_pressed", 32'(key_pressed), 32'h1);
      check("post_reset_events", 32'(ev_cnt - e0), 32'd1);
      check("post_reset_no_err", 32'(err_cnt - r0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
